frac_to_decimal_seq: RTL

Sequential, parametrised converter from an unsigned binary fraction to a fixed number of decimal digits, with a per-digit 7-segment encoding. It generalises the fractional-digit display path of the fixed-point calculator to any fraction width and digit count. It uses an iterative multiply-by-ten datapath (one digit per clock) and a start/done handshake, so it sits between the calculator result register and the display drivers.

---
 rtl/frac_to_decimal_seq.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/frac_to_decimal_seq.sv
`default_nettype none
// ============================================================================
// Module   : frac_to_decimal_seq
// Purpose  : Converts an unsigned binary fraction (frac_in / 2^FRAC_W) into
//            DIGITS truncated decimal digits, one digit per clock, using a
//            multiply-by-ten residue datapath. It also produces a per-digit
//            7-segment encoding. A start/done handshake frames each
//            conversion.
// Params   : FRAC_W  (1..16) fraction width in bits
//            DIGITS  (1..8)  decimal digits produced, tenths first
// Ports    : clk        - sole clock, rising edge
//            rst_n      - asynchronous active-low reset
//            start      - conversion request, sampled only while busy = 0
//            frac_in    - fraction, sampled in the start-accept cycle only
//            busy       - high while digits are being generated
//            done       - one-cycle pulse when a new result is presented
//            digits_bcd - BCD result, tenths in the top nibble
//            seg_out    - per-digit segment code, tenths in the top 7 bits
// Config   : FRAC_SEG_SIM_EN defined   -> seg field = digit zero-extended
//            FRAC_SEG_SIM_EN undefined -> active-low common-anode gfedcba
// Revision : 1.0 - initial release
// ============================================================================
module frac_to_decimal_seq #(
    parameter int FRAC_W = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [FRAC_W-1:0]     frac_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits_bcd,
    output logic [7*DIGITS-1:0]   seg_out
);

    localparam int c_cnt_w  = $clog2(DIGITS + 1);
    localparam int c_prod_w = FRAC_W + 4;

`ifdef FRAC_SEG_SIM_EN
    localparam logic [6:0] c_seg_zero = 7'b0000000;
`else
    localparam logic [6:0] c_seg_zero = 7'b1000000;
`endif

    generate
        if (FRAC_W < 1 || FRAC_W > 16 || DIGITS < 1 || DIGITS > 8) begin : g_param_check
            $error("frac_to_decimal_seq: FRAC_W must be 1..16 and DIGITS 1..8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   w_load;
    logic                   w_last;

    logic [FRAC_W-1:0]      r_residue;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [4*DIGITS-1:0]    r_shadow;
    logic [4*DIGITS-1:0]    w_shadow_next;

    logic [c_prod_w-1:0]    w_res_ext;
    logic [c_prod_w-1:0]    w_prod;
    logic [3:0]             w_digit;

    logic                   r_busy;
    logic                   r_done;
    logic [4*DIGITS-1:0]    r_digits;
    logic [7*DIGITS-1:0]    r_seg;
    logic [7*DIGITS-1:0]    w_seg_next;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
`ifdef FRAC_SEG_SIM_EN
        return {3'b000, d};
`else
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
`endif
    endfunction

    // residue * 10 as (r << 3) + (r << 1); the integer part lands in the top
    // nibble and can never exceed 9 because residue < 2^FRAC_W.
    assign w_res_ext = {4'b0000, r_residue};
    assign w_prod    = (w_res_ext << 3) + (w_res_ext << 1);
    assign w_digit   = w_prod[FRAC_W +: 4];
    assign w_last    = (r_cnt == c_cnt_w'(DIGITS - 1));

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_CONV;
                    w_load       = 1'b1;
                end
            end
            S_CONV: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_next_state = S_CONV;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Digit k (k = 0 is tenths) goes to nibble DIGITS-1-k of the shadow.
    always_comb begin
        w_shadow_next = r_shadow;
        if (r_state == S_CONV) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (r_cnt == c_cnt_w'(k)) begin
                    w_shadow_next[4*(DIGITS-1-k) +: 4] = w_digit;
                end
            end
        end
    end

    always_comb begin
        w_seg_next = '0;
        for (int k = 0; k < DIGITS; k++) begin
            w_seg_next[7*k +: 7] = seg_encode(w_shadow_next[4*k +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_residue <= '0;
            r_cnt     <= '0;
            r_shadow  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_digits  <= '0;
            r_seg     <= {DIGITS{c_seg_zero}};
        end else begin
            r_state  <= w_next_state;
            r_shadow <= w_shadow_next;
            r_busy   <= (w_next_state == S_CONV);
            r_done   <= (w_next_state == S_DONE);
            if (w_load) begin
                r_residue <= frac_in;
                r_cnt     <= '0;
            end else if (r_state == S_CONV) begin
                r_residue <= w_prod[FRAC_W-1:0];
                r_cnt     <= r_cnt + c_cnt_w'(1);
            end
            // Publish the complete result (including the final digit) on the
            // edge that enters DONE so done and the new value appear together.
            if (r_state == S_CONV && w_last) begin
                r_digits <= w_shadow_next;
                r_seg    <= w_seg_next;
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign digits_bcd = r_digits;
    assign seg_out    = r_seg;

endmodule
`default_nettype wire
